// File: rtl/key_debounce_if.sv
// Switch-side signal bundle: raw active-low key pin in, debounced level, event strobes and press count out.
// The debouncer uses the slave modport; whatever drives the pin and consumes the events uses master.
interface key_debounce_if;
    logic       key_in;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    modport master (
        output key_in,
        input  key_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  press_count
    );

    modport slave (
        input  key_in,
        output key_level,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output press_count
    );
endinterface

// File: rtl/key_debounce.sv
// Debounces an active-low mechanical key into a clean pressed level with press, release and
// long-press strobes and a wrapping press counter.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | released and stable, waiting for key_s to go low
// PRESS_WAIT   | key_s low, counting dcnt until the press is accepted
// HELD         | press accepted, lcnt counting towards the long-press point
// RELEASE_WAIT | key_s high while pressed, counting dcnt; lcnt frozen
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned LONG_CYCLES     = 25_000_000
) (
    input  logic           ext_clk_25m,
    input  logic           ext_rst_n,
    key_debounce_if.slave  bus
);

    localparam int unsigned    DW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]  DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0]  DCNT_ONE  = DW'(1);
    localparam logic [24:0]    LCNT_LAST = 25'(LONG_CYCLES - 1);
    localparam logic [24:0]    LCNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          w_key_s;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_nxt;
    logic [24:0]   r_lcnt;
    logic [24:0]   w_lcnt_nxt;
    logic          r_long_fired;
    logic          w_long_fired_nxt;
    logic          r_key_level;
    logic          w_key_level_nxt;
    logic          r_press_pulse;
    logic          w_press_pulse_nxt;
    logic          r_release_pulse;
    logic          w_release_pulse_nxt;
    logic          r_long_pulse;
    logic          w_long_pulse_nxt;
    logic [7:0]    r_press_count;
    logic [7:0]    w_press_count_nxt;

    // Two-flop synchronizer; idles high so reset looks like a released key.
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.key_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_s = r_sync2;

    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_dcnt_nxt          = r_dcnt;
        w_lcnt_nxt          = r_lcnt;
        w_long_fired_nxt    = r_long_fired;
        w_key_level_nxt     = r_key_level;
        w_press_pulse_nxt   = 1'b0;
        w_release_pulse_nxt = 1'b0;
        w_long_pulse_nxt    = 1'b0;
        w_press_count_nxt   = r_press_count;

        case (r_state)
            ST_IDLE: begin
                if (!w_key_s) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_dcnt_nxt  = '0;
                end
            end

            ST_PRESS_WAIT: begin
                if (w_key_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state_nxt       = ST_HELD;
                    w_key_level_nxt   = 1'b1;
                    w_press_pulse_nxt = 1'b1;
                    w_lcnt_nxt        = '0;
                    w_long_fired_nxt  = 1'b0;
                    w_press_count_nxt = r_press_count + 8'd1;
                end else begin
                    w_dcnt_nxt = r_dcnt + DCNT_ONE;
                end
            end

            ST_HELD: begin
                // Saturate so a very long hold can never wrap back onto the long-press point.
                if (r_lcnt != LCNT_MAX) begin
                    w_lcnt_nxt = r_lcnt + 25'd1;
                end
                if ((r_lcnt == LCNT_LAST) && !r_long_fired) begin
                    w_long_pulse_nxt = 1'b1;
                    w_long_fired_nxt = 1'b1;
                end
                if (w_key_s) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_dcnt_nxt  = '0;
                end
            end

            ST_RELEASE_WAIT: begin
                if (!w_key_s) begin
                    w_state_nxt = ST_HELD;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state_nxt         = ST_IDLE;
                    w_key_level_nxt     = 1'b0;
                    w_release_pulse_nxt = 1'b1;
                end else begin
                    w_dcnt_nxt = r_dcnt + DCNT_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_dcnt          <= '0;
            r_lcnt          <= '0;
            r_long_fired    <= 1'b0;
            r_key_level     <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_press_count   <= 8'd0;
        end else begin
            r_dcnt          <= w_dcnt_nxt;
            r_lcnt          <= w_lcnt_nxt;
            r_long_fired    <= w_long_fired_nxt;
            r_key_level     <= w_key_level_nxt;
            r_press_pulse   <= w_press_pulse_nxt;
            r_release_pulse <= w_release_pulse_nxt;
            r_long_pulse    <= w_long_pulse_nxt;
            r_press_count   <= w_press_count_nxt;
        end
    end

    assign bus.key_level     = r_key_level;
    assign bus.press_pulse   = r_press_pulse;
    assign bus.release_pulse = r_release_pulse;
    assign bus.long_pulse    = r_long_pulse;
    assign bus.press_count   = r_press_count;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_debounce;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n_press;
    int   n_release;
    int   n_long;
    int   snap_press;
    int   snap_release;
    int   snap_long;

    key_debounce_if kif ();

    key_debounce #(
        .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES    (32)
    ) dut (
        .ext_clk_25m(clk),
        .ext_rst_n  (rst_n),
        .bus        (kif)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Strobe tallies; each registered pulse is seen once on the following rising edge.
    always @(posedge clk) begin
        if (kif.press_pulse === 1'b1)   n_press++;
        if (kif.release_pulse === 1'b1) n_release++;
        if (kif.long_pulse === 1'b1)    n_long++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        snap_press   = n_press;
        snap_release = n_release;
        snap_long    = n_long;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        n_press    = 0;
        n_release  = 0;
        n_long     = 0;
        rst_n      = 1'b0;
        kif.key_in = 1'b1;
        wait_n(3);
        chk("rst_level", 32'(kif.key_level), 0);
        chk("rst_count", 32'(kif.press_count), 0);
        chk("rst_pulses", 32'({kif.press_pulse, kif.release_pulse, kif.long_pulse}), 0);
        rst_n = 1'b1;

        // Idle
        snap();
        wait_n(100);
        chk("idle_level", 32'(kif.key_level), 0);
        chk("idle_count", 32'(kif.press_count), 0);
        chk("idle_no_pulses", 32'(n_press + n_release + n_long - snap_press - snap_release - snap_long), 0);

        // Clean press, hold 20 cycles, release
        kif.key_in = 1'b0;
        wait_n(10);
        chk("clean_press_early", 32'(kif.press_pulse), 0);
        chk("clean_level_early", 32'(kif.key_level), 0);
        wait_n(1);
        chk("clean_press_pulse", 32'(kif.press_pulse), 1);
        chk("clean_level_high", 32'(kif.key_level), 1);
        chk("clean_count_1", 32'(kif.press_count), 1);
        wait_n(1);
        chk("clean_press_one_cycle", 32'(kif.press_pulse), 0);
        wait_n(8);
        kif.key_in = 1'b1;
        wait_n(10);
        chk("clean_release_early", 32'(kif.release_pulse), 0);
        chk("clean_level_still_high", 32'(kif.key_level), 1);
        wait_n(1);
        chk("clean_release_pulse", 32'(kif.release_pulse), 1);
        chk("clean_level_low", 32'(kif.key_level), 0);
        wait_n(1);
        chk("clean_release_one_cycle", 32'(kif.release_pulse), 0);
        chk("clean_no_long", 32'(n_long), 0);

        // Bounce rejection
        snap();
        kif.key_in = 1'b0; wait_n(5);
        kif.key_in = 1'b1; wait_n(3);
        kif.key_in = 1'b0; wait_n(5);
        kif.key_in = 1'b1; wait_n(3);
        wait_n(20);
        chk("bounce_no_press", 32'(n_press - snap_press), 0);
        chk("bounce_no_release", 32'(n_release - snap_release), 0);
        chk("bounce_level", 32'(kif.key_level), 0);
        chk("bounce_count", 32'(kif.press_count), 1);
        kif.key_in = 1'b0;
        wait_n(10);
        chk("after_bounce_press_early", 32'(kif.press_pulse), 0);
        wait_n(1);
        chk("after_bounce_press", 32'(kif.press_pulse), 1);
        chk("after_bounce_count", 32'(kif.press_count), 2);
        kif.key_in = 1'b1;
        wait_n(11);
        chk("after_bounce_release", 32'(kif.release_pulse), 1);

        // Long press with a short high glitch afterwards
        wait_n(2);
        snap();
        kif.key_in = 1'b0;
        wait_n(11);
        chk("long_press_pulse", 32'(kif.press_pulse), 1);
        chk("long_press_count", 32'(kif.press_count), 3);
        wait_n(31);
        chk("long_early", 32'(kif.long_pulse), 0);
        wait_n(1);
        chk("long_pulse", 32'(kif.long_pulse), 1);
        wait_n(1);
        chk("long_one_cycle", 32'(kif.long_pulse), 0);
        wait_n(15);
        kif.key_in = 1'b1; wait_n(3);
        kif.key_in = 1'b0; wait_n(40);
        chk("glitch_level_held", 32'(kif.key_level), 1);
        chk("glitch_no_release", 32'(n_release - snap_release), 0);
        chk("long_only_once", 32'(n_long - snap_long), 1);
        kif.key_in = 1'b1;
        wait_n(11);
        chk("long_release_pulse", 32'(kif.release_pulse), 1);
        chk("long_release_level", 32'(kif.key_level), 0);

        // Count wrap: 252 more presses reach 255, the next one wraps to 0
        wait_n(1);
        snap();
        for (int i = 0; i < 252; i++) begin
            kif.key_in = 1'b0; wait_n(11);
            kif.key_in = 1'b1; wait_n(11);
        end
        chk("wrap_count_255", 32'(kif.press_count), 255);
        kif.key_in = 1'b0;
        wait_n(10);
        chk("wrap_count_before", 32'(kif.press_count), 255);
        wait_n(1);
        chk("wrap_press_pulse", 32'(kif.press_pulse), 1);
        chk("wrap_count_0", 32'(kif.press_count), 0);
        kif.key_in = 1'b1;
        wait_n(11);
        chk("wrap_press_total", 32'(n_press - snap_press), 253);

        // Reset during RELEASE_WAIT
        kif.key_in = 1'b0;
        wait_n(11);
        chk("mid_press_count", 32'(kif.press_count), 1);
        wait_n(3);
        kif.key_in = 1'b1;
        wait_n(5);
        chk("mid_level_in_release_wait", 32'(kif.key_level), 1);
        snap();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(kif.key_level), 0);
        chk("mid_rst_count", 32'(kif.press_count), 0);
        chk("mid_rst_pulses", 32'({kif.press_pulse, kif.release_pulse, kif.long_pulse}), 0);
        wait_n(2);
        rst_n = 1'b1;
        wait_n(20);
        chk("mid_no_release", 32'(n_release - snap_release), 0);
        chk("mid_level_after", 32'(kif.key_level), 0);
        chk("mid_count_after", 32'(kif.press_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-side companion to the buzzer driver. It samples a raw, bouncing, active-low mechanical switch/key on the 25 MHz board clock and produces a clean active-high level plus single-cycle press, release and long-press events. It also keeps a wrapping press count. Sits between the board pin and any block that consumes switch state, such as the beep generator's enable.

## Interface
- DEBOUNCE_CYCLES, 500_000: cycles the synchronized input must stay stable before a change is accepted (20 ms at 25 MHz); legal range 2 to 2^24.
- LONG_CYCLES, 25_000_000: accepted-hold cycles before long_pulse fires (1 s); must exceed DEBOUNCE_CYCLES; maximum 2^25.
- ext_clk_25m  in  1  system clock, 25 MHz, rising edge.
- ext_rst_n  in  1  asynchronous, active-low reset.
- key_in  in  1  raw switch pin, active-low (0 = pressed), asynchronous to the clock.
- key_level  out  1  debounced state, 1 = pressed.
- press_pulse  out  1  one-cycle strobe when a press is accepted.
- release_pulse  out  1  one-cycle strobe when a release is accepted.
- long_pulse  out  1  one-cycle strobe, at most once per accepted press.
- press_count  out  8  number of accepted presses, modulo 256.

## Operation
- Synchronizer: two flops on key_in, both reset to 1. Its output key_s is the only input the logic below uses.
- Debounce counter dcnt is sized by $clog2(DEBOUNCE_CYCLES). Long counter lcnt is 25 bits. Both are unsigned, and neither wraps under legal parameters.
- FSM states and transitions:
  - IDLE (key_level=0): if key_s=0, go to PRESS_WAIT with dcnt=0.
  - PRESS_WAIT (key_level=0):
    - if key_s=1, return to IDLE (bounce rejected; no output).
    - else if dcnt=DEBOUNCE_CYCLES-1, go to HELD: assert press_pulse and key_level, set lcnt=0, clear long_fired, and increment press_count.
    - otherwise dcnt+1.
  - HELD (key_level=1):
    - lcnt+1 each cycle.
    - when lcnt=LONG_CYCLES-1 and long_fired=0, assert long_pulse and set long_fired.
    - if key_s=1, go to RELEASE_WAIT with dcnt=0.
  - RELEASE_WAIT (key_level=1, lcnt frozen):
    - if key_s=0, return to HELD; lcnt resumes from its frozen value.
    - else if dcnt=DEBOUNCE_CYCLES-1, go to IDLE: assert release_pulse and clear key_level.
    - otherwise dcnt+1.
- All outputs are registered.
- press_pulse, release_pulse and long_pulse are mutually exclusive. LONG_CYCLES > DEBOUNCE_CYCLES guarantees long_pulse never coincides with press_pulse.
- press_count wraps from 255 to 0 with no flag.
- long_fired prevents a second long_pulse within the same accepted press, including across bounces in RELEASE_WAIT.

## Timing
- Reset values: state=IDLE, key_level=0, all pulses=0, press_count=0, dcnt=0, lcnt=0, long_fired=0, synchronizer flops=1.
- Reset is asserted asynchronously. It is released synchronously through the flops' normal sampling; no reset synchronizer is inside this block.
- Reset asserted mid-operation returns to the reset values immediately. No pulse is emitted on the way out.
- Let E0 be the first clock edge that samples a new key_in level. key_s changes at E0+1 and the FSM reacts at E0+2.
- Press latency: if key_in is held stable, press_pulse and key_level are high after edge E0+DEBOUNCE_CYCLES+2. The pulse lasts exactly one cycle.
- Release latency: the same formula, measured from the release edge, applies to release_pulse and key_level falling.
- Long-press latency: long_pulse goes high LONG_CYCLES edges after press_pulse's edge, assuming no bounce. Each bounce cycle spent in RELEASE_WAIT delays it by that many cycles.
- Glitch rejection: any low excursion on key_s shorter than DEBOUNCE_CYCLES cycles produces no output. The same holds for a high excursion while pressed.

## Test plan
Bench parameters are DEBOUNCE_CYCLES=8 and LONG_CYCLES=32.
- Reset then idle: key_in=1 for 100 cycles, then key_level=0, no pulses, press_count=0.
- Clean press and release:
  - drop key_in at E0 and hold 20 cycles: press_pulse high after E0+10 for one cycle, key_level=1, press_count=1.
  - raise key_in and hold: release_pulse at +10 cycles, key_level=0.
- Bounce rejection:
  - key_in low 5 cycles, high 3, low 5, high 3, then high: no pulses, key_level stays 0.
  - then a stable low: press exactly 10 cycles after the last falling edge.
- Long press: hold low 60 cycles, giving press_pulse at E0+10 and long_pulse at E0+42. long_pulse fires only once; a 3-cycle high glitch afterwards causes no second long_pulse and no release.
- Wrap: 256 clean presses take press_count from 255 to 0 on the 256th press_pulse.
- Reset mid-press: assert ext_rst_n=0 during RELEASE_WAIT. All outputs go to 0 immediately, and no release_pulse appears after reset is removed with key_in=1.
